jtag_master: RTL and testbench



---
 rtl/jtag_master_pkg.sv | 48 ++++
 rtl/jtag_master_tck.sv | 48 ++++
 rtl/jtag_master.sv | 159 +++++++++++++++
 tb/tb_jtag_master.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtag_master_pkg
// Description : Op encodings, FSM states and TMS header/footer patterns
//               shared by the JTAG master.
// Revision    : 1.0 - initial release
// ============================================================================
package jtag_master_pkg;

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_DR    = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_FTR   = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    // TMS patterns are sent LSB first
    localparam logic [5:0] RESET_TMS  = 6'b011111;
    localparam logic [2:0] RESET_LEN  = 3'd6;
    localparam logic [5:0] HDR_DR     = 6'b000001;
    localparam logic [2:0] HDR_DR_LEN = 3'd3;
    localparam logic [5:0] HDR_IR     = 6'b000011;
    localparam logic [2:0] HDR_IR_LEN = 3'd4;
    localparam logic [1:0] FTR        = 2'b01;
    localparam logic [2:0] FTR_LEN    = 3'd2;

    typedef struct packed {
        logic [5:0] tms;
        logic [2:0] len;
    } hdr_t;

    function automatic hdr_t hdr_for(input logic [1:0] op);
        hdr_t h;
        case (op)
            OP_IR:   h = '{tms: HDR_IR, len: HDR_IR_LEN};
            OP_DR:   h = '{tms: HDR_DR, len: HDR_DR_LEN};
            default: h = '{tms: RESET_TMS, len: RESET_LEN};
        endcase
        return h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_master_tck.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tck_gen
// Description : TCK divider; one-clk fall/rise strobes mark bit boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tck,
    output logic fall_stb,
    output logic rise_stb
);

    localparam int              c_cnt_w    = $clog2(2 * CLK_DIV);
    localparam logic [c_cnt_w-1:0] c_rise_cnt = c_cnt_w'(CLK_DIV);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(2 * CLK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_tck;

    // Count 0 opens the low phase, count CLK_DIV opens the high phase
    assign fall_stb = run && (r_cnt == '0);
    assign rise_stb = run && (r_cnt == c_rise_cnt);
    assign tck      = r_tck;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else if (!run) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else begin
            r_cnt <= (r_cnt == c_last_cnt) ? '0 : r_cnt + c_cnt_w'(1);
            if (fall_stb) begin
                r_tck <= 1'b0;
            end else if (rise_stb) begin
                r_tck <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/jtag_master.sv
`default_nettype none
// ============================================================================
// Module      : jtag_master
// Description : Command-driven JTAG initiator: TAP reset, IR/DR scans of
//               1..32 bits, captured TDO returned over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_master
    import jtag_master_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [4:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);

    state_e             r_state, w_state_nxt;
    logic [1:0]         r_op;
    logic [4:0]         r_len;
    logic [MAX_LEN-1:0] r_data;
    logic [MAX_LEN-1:0] r_rsp_data;
    logic [5:0]         r_idx, w_idx_nxt;
    logic               r_tms, w_tms_nxt;
    logic               r_tdi, w_tdi_nxt;
    logic               w_run, w_fall, w_rise, w_accept;
    logic               w_hdr_done, w_shift_done, w_ftr_done;
    logic [4:0]         w_cap_idx;
    hdr_t               w_hdr;

    jtag_tck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tck_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (w_run),
        .tck      (tck),
        .fall_stb (w_fall),
        .rise_stb (w_rise)
    );

    assign w_accept     = cmd_valid && (r_state == ST_IDLE);
    assign w_run        = (r_state == ST_HDR) || (r_state == ST_SHIFT) || (r_state == ST_FTR);
    assign w_hdr        = hdr_for(r_op);
    // r_idx counts bits already launched in the current phase
    assign w_hdr_done   = (r_idx >= {3'b000, w_hdr.len});
    assign w_shift_done = (r_idx > {1'b0, r_len});
    assign w_ftr_done   = (r_idx >= {3'b000, FTR_LEN});
    assign w_cap_idx    = r_idx[4:0] - 5'd1;

    assign tms      = r_tms;
    assign tdi      = r_tdi;
    assign rsp_data = r_rsp_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_HDR;
            ST_HDR:   if (w_fall && w_hdr_done)
                          w_state_nxt = (r_op == OP_RESET) ? ST_RESP : ST_SHIFT;
            ST_SHIFT: if (w_fall && w_shift_done) w_state_nxt = ST_FTR;
            ST_FTR:   if (w_fall && w_ftr_done) w_state_nxt = ST_RESP;
            ST_RESP:  if (rsp_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Each fall strobe launches the next bit, or the first bit of the next phase
    always_comb begin
        w_tms_nxt = r_tms;
        w_tdi_nxt = r_tdi;
        w_idx_nxt = r_idx;
        cmd_ready = (r_state == ST_IDLE);
        rsp_valid = (r_state == ST_RESP);
        busy      = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: if (w_accept) w_idx_nxt = 6'd0;
            ST_HDR: if (w_fall) begin
                if (!w_hdr_done) begin
                    w_tms_nxt = w_hdr.tms[r_idx[2:0]];
                    w_idx_nxt = r_idx + 6'd1;
                end else if (r_op == OP_RESET) begin
                    w_idx_nxt = 6'd0;
                end else begin
                    w_tms_nxt = (r_len == 5'd0);
                    w_tdi_nxt = r_data[0];
                    w_idx_nxt = 6'd1;
                end
            end
            ST_SHIFT: if (w_fall) begin
                if (!w_shift_done) begin
                    w_tms_nxt = (r_idx[4:0] == r_len);
                    w_tdi_nxt = r_data[r_idx[4:0]];
                    w_idx_nxt = r_idx + 6'd1;
                end else begin
                    w_tms_nxt = FTR[0];
                    w_tdi_nxt = 1'b0;
                    w_idx_nxt = 6'd1;
                end
            end
            ST_FTR: if (w_fall) begin
                if (!w_ftr_done) begin
                    w_tms_nxt = FTR[r_idx[0]];
                    w_idx_nxt = r_idx + 6'd1;
                end else begin
                    w_idx_nxt = 6'd0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= OP_RESET;
            r_len      <= 5'd0;
            r_data     <= '0;
            r_idx      <= 6'd0;
            r_tms      <= 1'b1;
            r_tdi      <= 1'b0;
            r_rsp_data <= '0;
        end else begin
            r_idx <= w_idx_nxt;
            r_tms <= w_tms_nxt;
            r_tdi <= w_tdi_nxt;
            if (w_accept) begin
                r_op       <= ((cmd_op == OP_IR) || (cmd_op == OP_DR)) ? cmd_op : OP_RESET;
                r_len      <= cmd_len;
                r_data     <= cmd_data;
                r_rsp_data <= '0;
            end else if ((r_state == ST_SHIFT) && w_rise) begin
                r_rsp_data[w_cap_idx] <= tdo;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtag_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_master
// Description : Directed bench for jtag_master against a behavioural TAP
//               (4-bit IR, IDCODE and BYPASS).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_master;

    localparam logic [31:0] c_idcode    = 32'h1BA0_1477;
    localparam logic [3:0]  c_ir_idcode = 4'b0010;

    localparam logic [3:0] TLR = 4'd0,  RTI = 4'd1,  SELDR = 4'd2,  CAPDR = 4'd3;
    localparam logic [3:0] SHDR = 4'd4, EX1DR = 4'd5, PDR = 4'd6,   EX2DR = 4'd7;
    localparam logic [3:0] UPDR = 4'd8, SELIR = 4'd9, CAPIR = 4'd10, SHIR = 4'd11;
    localparam logic [3:0] EX1IR = 4'd12, PIR = 4'd13, EX2IR = 4'd14, UPIR = 4'd15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [4:0]  cmd_len = 5'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        busy;
    logic        tck, tms, tdi;
    logic        tdo = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    jtag_master #(
        .CLK_DIV (2),
        .MAX_LEN (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural TAP ----------------
    logic [3:0]  tap_st = TLR;
    logic [3:0]  ir = 4'b0010;
    logic [3:0]  ir_sr = 4'd0;
    logic [31:0] dr_sr = 32'd0;
    logic        bp = 1'b0;

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
        case (s)
            TLR:     return m ? TLR   : RTI;
            RTI:     return m ? SELDR : RTI;
            SELDR:   return m ? SELIR : CAPDR;
            CAPDR:   return m ? EX1DR : SHDR;
            SHDR:    return m ? EX1DR : SHDR;
            EX1DR:   return m ? UPDR  : PDR;
            PDR:     return m ? EX2DR : PDR;
            EX2DR:   return m ? UPDR  : SHDR;
            UPDR:    return m ? SELDR : RTI;
            SELIR:   return m ? TLR   : CAPIR;
            CAPIR:   return m ? EX1IR : SHIR;
            SHIR:    return m ? EX1IR : SHIR;
            EX1IR:   return m ? UPIR  : PIR;
            PIR:     return m ? EX2IR : PIR;
            EX2IR:   return m ? UPIR  : SHIR;
            default: return m ? SELDR : RTI;
        endcase
    endfunction

    always @(posedge tck) begin
        case (tap_st)
            TLR:   ir <= c_ir_idcode;
            CAPIR: ir_sr <= 4'b0101;
            SHIR:  ir_sr <= {tdi, ir_sr[3:1]};
            UPIR:  ir <= ir_sr;
            CAPDR: if (ir == c_ir_idcode) dr_sr <= c_idcode; else bp <= 1'b0;
            SHDR:  if (ir == c_ir_idcode) dr_sr <= {tdi, dr_sr[31:1]}; else bp <= tdi;
            default: ;
        endcase
        tap_st <= tap_next(tap_st, tms);
    end

    always @(negedge tck) begin
        if (tap_st == SHIR)      tdo <= ir_sr[0];
        else if (tap_st == SHDR) tdo <= (ir == c_ir_idcode) ? dr_sr[0] : bp;
        else                     tdo <= 1'b0;
    end

    // ---------------- pin monitor ----------------
    int   rise_cnt = 0;
    logic tms_hist [0:4095];
    logic tdi_hist [0:4095];

    always @(posedge tck) begin
        tms_hist[rise_cnt % 4096] <= tms;
        tdi_hist[rise_cnt % 4096] <= tdi;
        rise_cnt <= rise_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [4:0] len, input logic [31:0] data,
                           output logic [31:0] rsp, output int lat, output int n,
                           output logic [63:0] tp, output logic [63:0] dp);
        int base;
        int g;
        g = 0;
        @(negedge clk);
        while (!cmd_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        base      = rise_cnt;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 400) begin
            @(posedge clk);
            #1 lat++;
        end
        check("rsp_valid_seen", {63'd0, rsp_valid}, 64'd1);
        rsp = rsp_data;
        n   = rise_cnt - base;
        tp  = '0;
        dp  = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < n) begin
                tp[i] = tms_hist[(base + i) % 4096];
                dp[i] = tdi_hist[(base + i) % 4096];
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    logic [31:0] rsp, r0;
    logic [63:0] tp, dp;
    int          lat, n, bad, rc, g;

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pins", {58'd0, tck, tms, tdi, cmd_ready, rsp_valid, busy}, 64'b010100);
        check("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
        @(negedge clk) rst_n = 1'b1;

        run_cmd(2'd0, 5'd0, 32'd0, rsp, lat, n, tp, dp);
        check("reset_rsp", {32'd0, rsp}, 64'd0);
        check("reset_lat", lat, 25);
        check("reset_tcks", n, 6);
        check("reset_tms", tp, 64'h1F);
        check("tms_idle", {63'd0, tms}, 64'd0);

        run_cmd(2'd1, 5'd3, 32'h2, rsp, lat, n, tp, dp);
        check("ir_idcode_rsp", {32'd0, rsp}, 64'h5);
        check("ir_lat", lat, 41);
        check("ir_tcks", n, 10);
        check("ir_tms", tp, 64'h183);
        check("ir_tdi", dp, 64'h20);

        run_cmd(2'd2, 5'd31, 32'd0, rsp, lat, n, tp, dp);
        check("dr_idcode_rsp", {32'd0, rsp}, {32'd0, c_idcode});
        check("dr32_lat", lat, 149);
        check("dr32_tms", tp, 64'h0000_000C_0000_0001);

        run_cmd(2'd1, 5'd3, 32'hF, rsp, lat, n, tp, dp);
        check("ir_bypass_rsp", {32'd0, rsp}, 64'h5);
        check("ir_bypass_tdi", dp, 64'hF0);

        run_cmd(2'd2, 5'd7, 32'hA5, rsp, lat, n, tp, dp);
        check("bypass_rsp", {32'd0, rsp}, 64'h4A);
        check("dr8_lat", lat, 53);
        check("dr8_tms", tp, 64'hC01);
        check("dr8_tdi", dp, 64'h528);

        run_cmd(2'd3, 5'd5, 32'hFFFF, rsp, lat, n, tp, dp);
        check("op3_rsp", {32'd0, rsp}, 64'd0);
        check("op3_tcks", n, 6);
        check("op3_tms", tp, 64'h1F);

        // back-pressure: response held while another command is offered
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_len   = 5'd0;
        cmd_data  = 32'd0;
        rc        = rise_cnt;
        @(posedge clk);
        #1 lat = 0;
        while (!rsp_valid && lat < 400) begin
            @(posedge clk);
            #1 lat++;
        end
        check("bp_lat", lat, 25);
        check("bp_tcks", rise_cnt - rc, 6);
        r0  = rsp_data;
        rc  = rise_cnt;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (cmd_ready || !rsp_valid || rsp_data !== r0 || tck) bad++;
        end
        check("bp_hold", bad, 0);
        check("bp_no_tck", rise_cnt - rc, 0);
        check("bp_rsp", {32'd0, r0}, 64'd1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle", {62'd0, cmd_ready, busy}, 64'b10);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check("bp_next_accept", {62'd0, cmd_ready, busy}, 64'b01);
        // rsp_ready stays high throughout this command
        lat = 0;
        while (!rsp_valid && lat < 400) begin
            @(posedge clk);
            #1 lat++;
        end
        check("rdy_high_lat", lat, 25);
        check("rdy_high_rsp", {32'd0, rsp_data}, 64'd1);
        @(posedge clk);
        #1;
        check("rdy_high_done", {62'd0, rsp_valid, busy}, 64'd0);
        rsp_ready = 1'b0;

        // asynchronous reset in the middle of bit 10 of a 32-bit DR scan
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_len   = 5'd31;
        cmd_data  = 32'hFFFF_FFFF;
        rc        = rise_cnt;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        g = 0;
        while (rise_cnt < rc + 14 && g < 300) begin
            @(posedge clk);
            #1 g++;
        end
        #3;
        check("pre_rst_pins", {61'd0, tck, tms, tdi}, 64'b101);
        rst_n = 1'b0;
        #1;
        check("async_rst_pins", {59'd0, tck, tms, tdi, rsp_valid, busy}, 64'b01000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_cmd(2'd0, 5'd0, 32'd0, rsp, lat, n, tp, dp);
        check("post_rst_reset_rsp", {32'd0, rsp}, 64'd0);
        run_cmd(2'd1, 5'd3, 32'h2, rsp, lat, n, tp, dp);
        check("post_rst_ir_rsp", {32'd0, rsp}, 64'h5);
        run_cmd(2'd2, 5'd31, 32'd0, rsp, lat, n, tp, dp);
        check("post_rst_idcode", {32'd0, rsp}, {32'd0, c_idcode});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
